// File: rtl/pointer_basic.sv
`default_nettype none
// ============================================================================
// Module      : pointer_basic
// Description : Running 32-bit accumulator behind a start/done handshake.
//               Each transaction takes one operand on d_i (vld/ack),
//               adds it to a persistent accumulator, and presents the
//               result on d_o (vld/ack).
//               One-hot FSM: READ -> ACCUMULATE -> WRITE.
// Revision    : 1.0 - initial release
// ============================================================================
module pointer_basic #(
    parameter logic [2:0] ap_ST_fsm_state1 = 3'd1,   // IDLE / READ
    parameter logic [2:0] ap_ST_fsm_state2 = 3'd2,   // ACCUMULATE
    parameter logic [2:0] ap_ST_fsm_state3 = 3'd4    // WRITE
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] d_i,
    input  logic        d_i_ap_vld,
    output logic        d_i_ap_ack,
    output logic [31:0] d_o,
    output logic        d_o_ap_vld,
    input  logic        d_o_ap_ack
);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [31:0] r_acc;
    logic [31:0] r_d_i;

    logic        w_in_read;
    logic        w_in_accum;
    logic        w_in_write;
    logic        w_accept;

    assign w_in_read  = (r_state == ap_ST_fsm_state1);
    assign w_in_accum = (r_state == ap_ST_fsm_state2);
    assign w_in_write = (r_state == ap_ST_fsm_state3);

    // An operand is taken only when a start request and valid data coincide in READ
    assign w_accept   = w_in_read & ap_start & d_i_ap_vld;

    // State register: reset forces READ, aborting any transaction in flight
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ap_ST_fsm_state1;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: ACCUMULATE is always a single cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ap_ST_fsm_state1: begin
                if (w_accept) begin
                    w_state_next = ap_ST_fsm_state2;
                end
            end
            ap_ST_fsm_state2: begin
                w_state_next = ap_ST_fsm_state3;
            end
            ap_ST_fsm_state3: begin
                if (d_o_ap_ack) begin
                    w_state_next = ap_ST_fsm_state1;
                end
            end
            default: begin
                w_state_next = ap_ST_fsm_state1;
            end
        endcase
    end

    // Handshake outputs decoded from the current state and live inputs
    always_comb begin
        d_i_ap_ack = w_accept;
        ap_idle    = w_in_read & ~ap_start;
        d_o_ap_vld = w_in_write;
        ap_done    = w_in_write & d_o_ap_ack;
        ap_ready   = w_in_write & d_o_ap_ack;
    end

    // Accumulator is always visible; consumers qualify it with d_o_ap_vld
    assign d_o = r_acc;

    // Datapath: capture operand in READ, add it (mod 2^32) in ACCUMULATE
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_d_i <= 32'd0;
            r_acc <= 32'd0;
        end else begin
            if (w_accept) begin
                r_d_i <= d_i;
            end
            if (w_in_accum) begin
                r_acc <= r_acc + r_d_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pointer_basic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pointer_basic
// Description : Self-checking bench for pointer_basic. A transaction-level
//               model keeps the expected accumulator as a plain 32-bit sum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pointer_basic;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] d_i;
    logic        d_i_ap_vld;
    logic        d_i_ap_ack;
    logic [31:0] d_o;
    logic        d_o_ap_vld;
    logic        d_o_ap_ack;

    int          tests;
    int          fails;
    logic [31:0] exp_acc;

    pointer_basic dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .d_i        (d_i),
        .d_i_ap_vld (d_i_ap_vld),
        .d_i_ap_ack (d_i_ap_ack),
        .d_o        (d_o),
        .d_o_ap_vld (d_o_ap_vld),
        .d_o_ap_ack (d_o_ap_ack)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs that must not matter outside READ get random values
    task automatic scramble();
        ap_start   = 1'($urandom_range(0, 1));
        d_i_ap_vld = 1'($urandom_range(0, 1));
        d_i        = $urandom;
    endtask

    // Release reset and check the post-reset outputs
    task automatic finish_reset();
        @(posedge ap_clk); #1;
        ap_rst     = 1'b0;
        ap_start   = 1'b0;
        d_i_ap_vld = 1'b0;
        d_o_ap_ack = 1'b0;
        exp_acc    = 32'd0;
        #1;
        chk32("rst_d_o",   d_o,        32'd0);
        chk1 ("rst_ovld",  d_o_ap_vld, 1'b0);
        chk1 ("rst_done",  ap_done,    1'b0);
        chk1 ("rst_ready", ap_ready,   1'b0);
        chk1 ("rst_idle",  ap_idle,    1'b1);
        chk1 ("rst_ack",   d_i_ap_ack, 1'b0);
        ap_start = 1'b1;
        #1;
        chk1 ("rst_idle_start", ap_idle,    1'b0);
        chk1 ("rst_ack_novld",  d_i_ap_ack, 1'b0);
        ap_start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        scramble();
        d_o_ap_ack = 1'b0;
        finish_reset();
    endtask

    // One transaction. abort_at: 0 none, 2 reset during ACCUMULATE,
    // 3 reset in WRITE instead of acknowledging.
    task automatic run_txn(input logic [31:0] data, input int vld_wait,
                           input int ack_wait, input int abort_at);
        for (int i = 0; i < vld_wait; i++) begin
            @(posedge ap_clk); #1;
            ap_start   = 1'b1;
            d_i_ap_vld = 1'b0;
            d_i        = $urandom;
            d_o_ap_ack = 1'($urandom_range(0, 1));
            #1;
            chk1("wait_ack",  d_i_ap_ack, 1'b0);
            chk1("wait_idle", ap_idle,    1'b0);
            chk1("wait_ovld", d_o_ap_vld, 1'b0);
            chk1("wait_done", ap_done,    1'b0);
        end
        // Accept cycle (N)
        @(posedge ap_clk); #1;
        ap_start   = 1'b1;
        d_i_ap_vld = 1'b1;
        d_i        = data;
        d_o_ap_ack = 1'($urandom_range(0, 1));
        #1;
        chk1("acc_ack",  d_i_ap_ack, 1'b1);
        chk1("acc_idle", ap_idle,    1'b0);
        chk1("acc_ovld", d_o_ap_vld, 1'b0);
        chk1("acc_done", ap_done,    1'b0);
        // ACCUMULATE cycle (N+1)
        @(posedge ap_clk); #1;
        scramble();
        d_o_ap_ack = 1'($urandom_range(0, 1));
        if (abort_at == 2) ap_rst = 1'b1;
        #1;
        chk1("s2_ack",  d_i_ap_ack, 1'b0);
        chk1("s2_ovld", d_o_ap_vld, 1'b0);
        chk1("s2_done", ap_done,    1'b0);
        if (abort_at == 2) begin
            finish_reset();
            return;
        end
        exp_acc = exp_acc + data;
        // WRITE cycles waiting for the consumer (N+2 ...)
        for (int i = 0; i < ack_wait; i++) begin
            @(posedge ap_clk); #1;
            scramble();
            d_o_ap_ack = 1'b0;
            #1;
            chk32("hold_d_o",  d_o,        exp_acc);
            chk1 ("hold_ovld", d_o_ap_vld, 1'b1);
            chk1 ("hold_done", ap_done,    1'b0);
            chk1 ("hold_rdy",  ap_ready,   1'b0);
            chk1 ("hold_ack",  d_i_ap_ack, 1'b0);
        end
        @(posedge ap_clk); #1;
        scramble();
        if (abort_at == 3) begin
            d_o_ap_ack = 1'b0;
            ap_rst     = 1'b1;
            #1;
            chk32("abort_d_o", d_o, exp_acc);
            finish_reset();
            return;
        end
        d_o_ap_ack = 1'b1;
        #1;
        chk32("out_d_o",   d_o,        exp_acc);
        chk1 ("out_ovld",  d_o_ap_vld, 1'b1);
        chk1 ("out_done",  ap_done,    1'b1);
        chk1 ("out_ready", ap_ready,   1'b1);
        chk1 ("out_ack",   d_i_ap_ack, 1'b0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_acc    = 32'd0;
        ap_rst     = 1'b1;
        ap_start   = 1'b0;
        d_i        = 32'd0;
        d_i_ap_vld = 1'b0;
        d_o_ap_ack = 1'b0;
        repeat (2) @(posedge ap_clk);
        finish_reset();

        // Basic transaction and running sum with a negative operand
        run_txn(32'd5, 0, 0, 0);
        run_txn(32'd3, 0, 0, 0);
        chk32("sum_8", exp_acc, 32'd8);
        run_txn(-32'sd10, 0, 0, 0);
        chk32("sum_m2", d_o, 32'hFFFF_FFFE);

        // Wrap-around from max positive
        do_reset();
        run_txn(32'h7FFF_FFFF, 0, 0, 0);
        run_txn(32'd1, 0, 0, 0);
        chk32("wrap", d_o, 32'h8000_0000);

        // Consumer stalls, then producer stalls
        run_txn($urandom, 0, 4, 0);
        run_txn($urandom, 3, 0, 0);

        // Idle: READ with no start request, stays put
        @(posedge ap_clk); #1;
        ap_start   = 1'b0;
        d_i_ap_vld = 1'b1;
        d_o_ap_ack = 1'b0;
        #1;
        chk1("idle_idle", ap_idle,    1'b1);
        chk1("idle_ack",  d_i_ap_ack, 1'b0);
        @(posedge ap_clk); #1;
        chk1("idle_ovld", d_o_ap_vld, 1'b0);
        chk1("idle_stay", ap_idle,    1'b1);

        // Reset in WRITE after acc=8, then fresh transaction
        do_reset();
        run_txn(32'd3, 0, 0, 0);
        run_txn(32'd5, 0, 0, 0);
        run_txn(32'd7, 0, 1, 3);
        run_txn(32'd2, 0, 0, 0);
        chk32("after_abort3", d_o, 32'd2);

        // Reset during ACCUMULATE must not update the sum
        run_txn(32'd9, 0, 0, 2);
        run_txn(32'd4, 0, 0, 0);
        chk32("after_abort2", d_o, 32'd4);

        // Randomized back-to-back and stalled traffic
        for (int k = 0; k < 25; k++) begin
            run_txn($urandom, $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pointer_basic.md
POINTER_BASIC -- requirements
Module: pointer_basic

Interface
REQ-001 SHALL have parameter ap_ST_fsm_state1, default 3'd1: one-hot code of the IDLE/READ state.
REQ-002 SHALL have parameter ap_ST_fsm_state2, default 3'd2: one-hot code of the ACCUMULATE state.
REQ-003 SHALL have parameter ap_ST_fsm_state3, default 3'd4: one-hot code of the WRITE state.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port ap_start, input, 1 bit: start request for one transaction.
REQ-007 SHALL have port ap_done, output, 1 bit: transaction complete pulse.
REQ-008 SHALL have port ap_idle, output, 1 bit: block idle.
REQ-009 SHALL have port ap_ready, output, 1 bit: ready for the next start.
REQ-010 SHALL have port d_i, input, 32 bits: operand in, signed two's complement.
REQ-011 SHALL have port d_i_ap_vld, input, 1 bit: d_i valid.
REQ-012 SHALL have port d_i_ap_ack, output, 1 bit: d_i consumed.
REQ-013 SHALL have port d_o, output, 32 bits: accumulated result out.
REQ-014 SHALL have port d_o_ap_vld, output, 1 bit: d_o valid.
REQ-015 SHALL have port d_o_ap_ack, input, 1 bit: d_o accepted by the consumer.

Function
REQ-016 SHALL implement a running accumulator: each transaction performs acc = acc + d_i, then outputs acc on d_o.
REQ-017 SHALL keep acc (32-bit register) across transactions; it is cleared only by reset.
REQ-018 SHALL compute the addition modulo 2^32 (wrap-around); no saturation; no overflow flag.
REQ-019 SHALL use a 3-bit one-hot state register with states S1, S2, S3 as encoded by the parameters.
REQ-020 In S1, when ap_start=1 and d_i_ap_vld=1, SHALL assert d_i_ap_ack=1 (combinational), capture d_i into an input register, and move to S2.
REQ-021 In S1, when ap_start=0 or d_i_ap_vld=0, SHALL hold d_i_ap_ack=0 and remain in S1.
REQ-022 S2 SHALL last exactly one cycle: acc <= acc + captured d_i, then move to S3.
REQ-023 In S3, SHALL drive d_o=acc and d_o_ap_vld=1, and hold both steady until d_o_ap_ack=1.
REQ-024 In S3, when d_o_ap_ack=1, SHALL assert ap_done=1 and ap_ready=1 combinationally in that cycle, then move to S1.
REQ-025 In S3, when d_o_ap_ack=0, SHALL hold ap_done=0 and ap_ready=0 and remain in S3.
REQ-026 ap_idle SHALL be 1 only when in S1 and ap_start=0.
REQ-027 d_i_ap_ack SHALL be 0 outside S1.
REQ-028 d_o_ap_vld SHALL be 0 outside S3.
REQ-029 d_o SHALL show the current acc value at all times; it is meaningful only while d_o_ap_vld=1.
REQ-030 Minimum latency SHALL be: input accepted in cycle N; d_o_ap_vld=1 in cycle N+2; ap_done in the cycle of d_o_ap_ack (earliest N+2).
REQ-031 If ap_start stays high, SHALL accept the next transaction in the first S1 cycle after returning (back-to-back, 3-cycle throughput).
REQ-032 Input changes while in S2 or S3 SHALL have no effect.

Reset
REQ-033 With ap_rst=1 at a clock edge, SHALL set state=S1, acc=0 and the input register to 0, overriding any transaction in progress.
REQ-034 Outputs SHALL follow from the reset state: ap_done=0, ap_ready=0, d_i_ap_ack=0, d_o_ap_vld=0, d_o=0, and ap_idle=!ap_start.
REQ-035 A transaction aborted by reset SHALL NOT update acc after reset.

Verification
REQ-036 Bench SHALL cover: reset, then ap_start=1 with d_i=5 and vld=1, and d_o_ap_ack=1 -> ack in cycle N, d_o=5 with vld in N+2, ap_done=ap_ready=1 in N+2.
REQ-037 Bench SHALL cover: following transactions d_i=3, then d_i=-10 -> d_o=8, then d_o=-2 (0xFFFFFFFE).
REQ-038 Bench SHALL cover: reset, d_i=0x7FFFFFFF, then d_i=1 -> d_o=0x7FFFFFFF, then 0x80000000 (wrap).
REQ-039 Bench SHALL cover: d_o_ap_ack held low for 4 cycles in S3 -> d_o and d_o_ap_vld stable, ap_done=0; ap_done=1 only in the ack cycle.
REQ-040 Bench SHALL cover: ap_start=1 with d_i_ap_vld=0 for 3 cycles -> stays in S1, ack=0, ap_idle=0; proceeds once vld=1.
REQ-041 Bench SHALL cover: ap_rst asserted in S3 after acc=8 -> next cycle S1, d_o=0; next transaction d_i=2 -> d_o=2.
